// File: rtl/cache_fill_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Memory-side initiator for one cache. It owns the memory port, which takes
// 4 cycles for a read and 1 cycle for a write.
//   * On a miss it issues WORDS_PER_BLOCK pipelined word reads, one per cycle.
//     Each returned word is written into the cache data array.
//     fill_done pulses once the whole block has been written.
//   * It forwards write-through stores to memory as single-cycle writes.
//
// Build option:
//   FILL_CRIT_WORD_FIRST_EN  When defined, issue order and the returned-word
//                            index start at the missed word and wrap within
//                            the block. When undefined, the order is strictly
//                            ascending from word 0. Latency is the same in
//                            both builds.
//
// Handshakes:
//   miss_valid is a level request that stays high until fill_done.
//   wr_req is a level request that stays high until wr_ack.
//   fill_done and wr_ack are one-cycle pulses.
//   When both requests are seen in IDLE, the miss wins. The store waits and
//   is served after the fill completes.
//   mem_rvalid is a pulse that arrives 4 cycles after its read was issued.
//   It is only accepted while a fill is in flight (FILL or DRAIN).
//
// Ports:
//   clk, rst          rising-edge clock; synchronous active-high reset
//   miss_valid/addr   fill request and the byte address of the missing word
//   wr_req/addr/data  write-through store request
//   busy              high whenever the controller is not IDLE
//   fill_done         one-cycle pulse: block written, the tag may be updated
//   wr_ack            one-cycle pulse: the store was issued to memory
//   cache_we          data-array write strobe (combinational)
//   cache_word_idx    word index within the block for cache_we
//   cache_wdata       data for the data array (mem_rdata passed through)
//   mem_enable/wr     registered memory command
//   mem_addr/wdata    registered memory address (bit 0 always 0) and data
//   mem_rdata/rvalid  memory read data and its valid strobe
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int IDXW           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  fill_done,
  output logic                  wr_ack,
  output logic                  cache_we,
  output logic [IDXW-1:0]       cache_word_idx,
  output logic [15:0]           cache_wdata,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_rvalid
);

  // The counters carry one extra bit so that the full count N can be held.
  localparam int CW = IDXW + 1;
  localparam logic [CW-1:0] N_CNT    = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS_PER_BLOCK - 1);

  // This mask clears the word-in-block bits and the byte bit of an address.
  // The result is the block base address.
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'((1 << CW) - 1);
  // This mask forces an address to a 16-bit word boundary.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;      // block base of the fill in progress
  logic [IDXW-1:0]       start_q;     // first word index of the fill
  logic [CW-1:0]         issue_cnt;   // reads issued so far, including this cycle's
  logic [CW-1:0]         recv_cnt;    // reads returned so far

  logic [ADDR_WIDTH-1:0] base_d;
  logic [IDXW-1:0]       start_d;
  logic [IDXW-1:0]       issue_idx;
  logic [IDXW-1:0]       recv_idx;
  logic                  in_fill;

  // The base has all low bits clear, so OR-ing in the word offset gives the
  // word address. The offset can never carry into the tag bits.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [IDXW-1:0]       idx
  );
    return base | ADDR_WIDTH'({idx, 1'b0});
  endfunction

  always_comb begin
    base_d = miss_addr & BLK_MASK;
`ifdef FILL_CRIT_WORD_FIRST_EN
    start_d = miss_addr[IDXW:1];
`else
    start_d = '0;
`endif
    // IDXW-bit additions wrap naturally modulo WORDS_PER_BLOCK.
    issue_idx = start_q + issue_cnt[IDXW-1:0];
    recv_idx  = start_q + recv_cnt[IDXW-1:0];
    in_fill   = (state == S_FILL) || (state == S_DRAIN);

    // Returned data goes straight into the data array in the same cycle.
    cache_we       = in_fill && mem_rvalid;
    cache_word_idx = recv_idx;
    cache_wdata    = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      start_q    <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      busy       <= 1'b0;
      fill_done  <= 1'b0;
      wr_ack     <= 1'b0;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          fill_done <= 1'b0;
          wr_ack    <= 1'b0;
          if (miss_valid) begin
            // The first read goes out in the very next cycle. Its address is
            // built from the incoming request, because base_q and start_q are
            // only being loaded at this edge.
            base_q     <= base_d;
            start_q    <= start_d;
            issue_cnt  <= CW'(1);
            recv_cnt   <= '0;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= word_addr(base_d, start_d);
            busy       <= 1'b1;
            state      <= S_FILL;
          end else if (wr_req) begin
            mem_enable <= 1'b1;
            mem_wr     <= 1'b1;
            mem_addr   <= wr_addr & WORD_MASK;
            mem_wdata  <= wr_data;
            wr_ack     <= 1'b1;
            busy       <= 1'b1;
            state      <= S_WRITE;
          end
        end

        S_FILL: begin
          if (issue_cnt == N_CNT) begin
            mem_enable <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            mem_addr  <= word_addr(base_q, issue_idx);
            issue_cnt <= issue_cnt + CW'(1);
          end
        end

        S_DRAIN: begin
          // Wait here for the outstanding returns, which are handled below.
        end

        S_DONE: begin
          // miss_valid may still be high in this cycle. It is not looked at
          // again until the next IDLE cycle, and by then it has been dropped.
          fill_done <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        S_WRITE: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          wr_ack     <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // Returns may overlap the issue phase, so they are counted in both
      // FILL and DRAIN. The last return takes priority over the FILL to DRAIN
      // move made above.
      if (in_fill && mem_rvalid) begin
        if (recv_cnt == LAST_CNT) begin
          recv_cnt   <= '0;
          mem_enable <= 1'b0;
          fill_done  <= 1'b1;
          state      <= S_DONE;
        end else begin
          recv_cnt <= recv_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
`timescale 1ns/1ps
// Directed bench for cache_fill_ctrl with the default parameters
// (ADDR_WIDTH=16, WORDS_PER_BLOCK=8).
// Inputs are driven 1 ns after each rising edge. Outputs are sampled on the
// falling edge.
// Row / cycle k of a table is the k-th clock period after the request cycle.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_valid = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        busy, fill_done, wr_ack, cache_we;
  logic [2:0]  cache_word_idx;
  logic [15:0] cache_wdata;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  cache_fill_ctrl #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .fill_done(fill_done), .wr_ack(wr_ack),
    .cache_we(cache_we), .cache_word_idx(cache_word_idx), .cache_wdata(cache_wdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic        miss_valid;
    logic [15:0] miss_addr;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        rvalid;
    logic [15:0] rdata;
    logic        e_busy;
    logic        e_fill_done;
    logic        e_wr_ack;
    logic        e_cache_we;
    logic [2:0]  e_idx;
    logic        e_mem_en;
    logic        e_mem_wr;
    logic [15:0] e_mem_addr;
    logic        chk_addr;
    logic [15:0] e_mem_wdata;
    logic        chk_wdata;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] seq_a[8];   // expected mem_addr in cycles 1..8
  logic [2:0]  seq_i[8];   // expected cache_word_idx in cycles 5..12

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " fill_done"},  32'(fill_done),  32'd0);
    check({tag, " wr_ack"},     32'(wr_ack),     32'd0);
    check({tag, " cache_we"},   32'(cache_we),   32'd0);
    check({tag, " mem_enable"}, 32'(mem_enable), 32'd0);
    check({tag, " mem_wr"},     32'(mem_wr),     32'd0);
    check({tag, " mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, " mem_wdata"},  32'(mem_wdata),  32'd0);
  endtask

  task automatic set_seq_linear(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      seq_a[i] = base + 16'(2 * i);
      seq_i[i] = 3'(i);
    end
  endtask

  // Builds the cycle-by-cycle timeline of one fill from seq_a/seq_i.
  // With with_wr set, a store is held pending from cycle 0. It must show up in
  // cycle 15: DONE is cycle 13, IDLE is cycle 14.
  task automatic build_fill(input logic [15:0] addr, input logic with_wr,
                            input logic [15:0] waddr, input logic [15:0] wdata);
    int last;
    tbl.delete();
    last = with_wr ? 15 : 14;
    for (int c = 0; c <= last; c++) begin
      vec_t v;
      v.miss_valid  = (c <= 13);
      v.miss_addr   = addr;
      v.wr_req      = with_wr && (c <= 14);
      v.wr_addr     = waddr;
      v.wr_data     = wdata;
      v.rvalid      = (c >= 5) && (c <= 12);
      v.rdata       = 16'hA000 + 16'(c);
      v.e_busy      = ((c >= 1) && (c <= 13)) || (with_wr && c == 15);
      v.e_fill_done = (c == 13);
      v.e_wr_ack    = with_wr && (c == 15);
      v.e_cache_we  = (c >= 5) && (c <= 12);
      v.e_idx       = v.e_cache_we ? seq_i[c - 5] : 3'd0;
      v.e_mem_en    = ((c >= 1) && (c <= 8)) || (with_wr && c == 15);
      v.e_mem_wr    = with_wr && (c == 15);
      v.e_mem_addr  = ((c >= 1) && (c <= 8)) ? seq_a[c - 1] : waddr;
      v.chk_addr    = v.e_mem_en;
      v.e_mem_wdata = wdata;
      v.chk_wdata   = with_wr && (c == 15);
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[k]) begin
      string n;
      miss_valid = tbl[k].miss_valid;
      miss_addr  = tbl[k].miss_addr;
      wr_req     = tbl[k].wr_req;
      wr_addr    = tbl[k].wr_addr;
      wr_data    = tbl[k].wr_data;
      mem_rvalid = tbl[k].rvalid;
      mem_rdata  = tbl[k].rdata;
      @(negedge clk);
      n = $sformatf("%s c%0d", tag, k);
      check({n, " busy"},       32'(busy),       32'(tbl[k].e_busy));
      check({n, " fill_done"},  32'(fill_done),  32'(tbl[k].e_fill_done));
      check({n, " wr_ack"},     32'(wr_ack),     32'(tbl[k].e_wr_ack));
      check({n, " cache_we"},   32'(cache_we),   32'(tbl[k].e_cache_we));
      check({n, " mem_enable"}, 32'(mem_enable), 32'(tbl[k].e_mem_en));
      check({n, " mem_wr"},     32'(mem_wr),     32'(tbl[k].e_mem_wr));
      if (tbl[k].e_cache_we) begin
        check({n, " cache_word_idx"}, 32'(cache_word_idx), 32'(tbl[k].e_idx));
        check({n, " cache_wdata"},    32'(cache_wdata),    32'(tbl[k].rdata));
      end
      if (tbl[k].chk_addr)
        check({n, " mem_addr"}, 32'(mem_addr), 32'(tbl[k].e_mem_addr));
      if (tbl[k].chk_wdata)
        check({n, " mem_wdata"}, 32'(mem_wdata), 32'(tbl[k].e_mem_wdata));
      step();
    end
    miss_valid = 1'b0;
    wr_req     = 1'b0;
    mem_rvalid = 1'b0;
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset, then idle with a stray mem_rvalid: every output must stay 0.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_zero($sformatf("reset_idle%0d", i));
      step();
    end
    mem_rvalid = 1'b0;
    step();

    // Miss at 0x1236.
`ifdef FILL_CRIT_WORD_FIRST_EN
    seq_a = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
    seq_i = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
`else
    seq_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    seq_i = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    build_fill(16'h1236, 1'b0, 16'h0000, 16'h0000);
    run_table("fill1236");

    // Single write-through store.
    wr_req  = 1'b1;
    wr_addr = 16'h0040;
    wr_data = 16'hBEEF;
    @(negedge clk);
    check("wr c0 wr_ack", 32'(wr_ack), 32'd0);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    check("wr c1 mem_enable", 32'(mem_enable), 32'd1);
    check("wr c1 mem_wr",     32'(mem_wr),     32'd1);
    check("wr c1 mem_addr",   32'(mem_addr),   32'h0040);
    check("wr c1 mem_wdata",  32'(mem_wdata),  32'hBEEF);
    check("wr c1 wr_ack",     32'(wr_ack),     32'd1);
    check("wr c1 busy",       32'(busy),       32'd1);
    step();
    @(negedge clk);
    check("wr c2 busy",       32'(busy),       32'd0);
    check("wr c2 wr_ack",     32'(wr_ack),     32'd0);
    check("wr c2 mem_enable", 32'(mem_enable), 32'd0);
    check("wr c2 mem_wr",     32'(mem_wr),     32'd0);
    step();

    // Miss at the top of the address space with a store pending at the same
    // time. Start word is 0 in both builds, so the order is ascending.
    set_seq_linear(16'hFFF0);
    build_fill(16'hFFF0, 1'b1, 16'h1234, 16'h5A5A);
    run_table("fillFFF0_wr");

    // Reset in cycle 7 of a fill.
    miss_valid = 1'b1;
    miss_addr  = 16'h2468;
    for (int c = 0; c <= 6; c++) begin
      mem_rvalid = (c >= 5);
      mem_rdata  = 16'hC000 + 16'(c);
      @(negedge clk);
      if (c >= 1) begin
        check($sformatf("rstfill c%0d busy", c),       32'(busy),       32'd1);
        check($sformatf("rstfill c%0d mem_enable", c), 32'(mem_enable), 32'd1);
      end
      if (c >= 5)
        check($sformatf("rstfill c%0d cache_we", c), 32'(cache_we), 32'd1);
      step();
    end
    miss_valid = 1'b0;
    mem_rvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    check_idle_zero("rstfill c8");
    for (int c = 9; c <= 10; c++) begin
      step();
      @(negedge clk);
      check($sformatf("rstfill c%0d cache_we", c), 32'(cache_we), 32'd0);
      check($sformatf("rstfill c%0d busy", c),     32'(busy),     32'd0);
    end
    mem_rvalid = 1'b0;
    step();

    // A new miss after the abort must fill normally.
    set_seq_linear(16'h0100);
    build_fill(16'h0102 & 16'hFFF0, 1'b0, 16'h0000, 16'h0000);
    run_table("fill0100");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
